// File: rtl/prog_seq.sv
// rtl/prog_seq.sv - instruction-fetch program counter sequencer
//
// Holds the program counter. Start launches one of NPROG programs from the
// ENTRY table. While a program runs, the sequencer supports stall, halt,
// absolute jump and signed relative branch. Its output drives the
// instruction-ROM address.
//
// Optional feature: define CALL_STACK_EN to build a DEPTH-entry hardware
// call/return stack. Without it, Call and Ret fall through to the lower
// priority controls, and StackErr is tied low.
//
// Ports:
//   Clk      in   clock, rising edge
//   Reset    in   asynchronous active-high reset
//   Start    in   launch program ProgSel (honoured in IDLE/DONE only)
//   ProgSel  in   program index sampled with Start
//   Stall    in   hold PC, state and stack this cycle
//   Halt     in   end current program (state -> DONE, PC holds)
//   Jump     in   absolute jump to Target
//   Branch   in   relative branch by Target when Taken
//   Taken    in   branch condition
//   Call     in   push return address, jump to Target (CALL_STACK_EN)
//   Ret      in   pop return address into PC (CALL_STACK_EN)
//   Target   in   absolute address or two's-complement offset
//   ProgCtr  out  current PC
//   Running  out  state == RUN
//   Done     out  state == DONE
//   StackErr out  sticky stack overflow/underflow flag
module prog_seq #(
  parameter int                 L     = 10,
  parameter int                 NPROG = 3,
  parameter logic [NPROG*L-1:0] ENTRY = {10'h200, 10'h100, 10'h000},
  parameter int                 DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [$clog2(NPROG)-1:0] ProgSel,
  input  logic                     Stall,
  input  logic                     Halt,
  input  logic                     Jump,
  input  logic                     Branch,
  input  logic                     Taken,
  input  logic                     Call,
  input  logic                     Ret,
  input  logic [L-1:0]             Target,
  output logic [L-1:0]             ProgCtr,
  output logic                     Running,
  output logic                     Done,
  output logic                     StackErr
);

  localparam int SW = $clog2(NPROG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [L-1:0] pc_d;
  logic [L-1:0] pc_inc;
  logic [L-1:0] entry_pc;
  logic         sel_ok;

  assign pc_inc = ProgCtr + L'(1);

  // Entry lookup. sel_ok stays low for ProgSel >= NPROG, so such a Start is ignored.
  always_comb begin
    entry_pc = '0;
    sel_ok   = 1'b0;
    for (int p = 0; p < NPROG; p++) begin
      if (ProgSel == SW'(p)) begin
        entry_pc = ENTRY[p*L +: L];
        sel_ok   = 1'b1;
      end
    end
  end

`ifdef CALL_STACK_EN
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [L-1:0]   stack_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] sp_m1;
  logic           err_q, err_d;
  logic           push_en;
  logic           stack_full;
  logic           stack_empty;

  assign sp_m1       = sp_q - SPW'(1);
  assign stack_full  = (sp_q == SPW'(DEPTH));
  assign stack_empty = (sp_q == '0);
  assign StackErr    = err_q;

  // Stack storage needs no reset: sp_q alone decides which entries are live.
  always_ff @(posedge Clk) begin
    if (push_en) begin
      stack_q[sp_q[IW-1:0]] <= pc_inc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = Call ^ Ret;
  assign StackErr   = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ProgCtr <= '0;
    end else begin
      state_q <= state_d;
      ProgCtr <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = ProgCtr;
`ifdef CALL_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start && sel_ok) begin
          state_d = S_RUN;
          pc_d    = entry_pc;
`ifdef CALL_STACK_EN
          sp_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (Stall) begin
          // Hold everything, stack included.
        end else if (Halt) begin
          state_d = S_DONE;
        end
`ifdef CALL_STACK_EN
        else if (Ret) begin
          if (stack_empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d = stack_q[sp_m1[IW-1:0]];
            sp_d = sp_m1;
          end
        end else if (Call) begin
          pc_d = Target;
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
          end
        end
`endif
        else if (Jump) begin
          pc_d = Target;
        end else if (Branch && Taken) begin
          // The add wraps modulo 2^L, so a negative offset branches backwards.
          pc_d = ProgCtr + Target;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Running = (state_q == S_RUN);
  assign Done    = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_seq.sv
// tb/tb_prog_seq.sv - directed scoreboard testbench for prog_seq
module tb_prog_seq;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] ProgSel;
  logic       Stall, Halt, Jump, Branch, Taken, Call, Ret;
  logic [9:0] Target;
  logic [9:0] ProgCtr;
  logic       Running, Done, StackErr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] pc;
    logic       run;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[$];

  prog_seq dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ProgSel  (ProgSel),
    .Stall    (Stall),
    .Halt     (Halt),
    .Jump     (Jump),
    .Branch   (Branch),
    .Taken    (Taken),
    .Call     (Call),
    .Ret      (Ret),
    .Target   (Target),
    .ProgCtr  (ProgCtr),
    .Running  (Running),
    .Done     (Done),
    .StackErr (StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    Start = 0; ProgSel = 0; Stall = 0; Halt = 0; Jump = 0;
    Branch = 0; Taken = 0; Call = 0; Ret = 0; Target = '0;
  endtask

  // Expected state after the next edge is queued with the stimulus, then
  // popped and compared once the edge has been taken.
  task automatic step(input string tag, input logic [9:0] pc, input logic run,
                      input logic done, input logic err);
    exp_t e;
    sb.push_back('{pc: pc, run: run, done: done, err: err});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"},   32'(ProgCtr),  32'(e.pc));
    check({tag, ".run"},  32'(Running),  32'(e.run));
    check({tag, ".done"}, 32'(Done),     32'(e.done));
    check({tag, ".err"},  32'(StackErr), 32'(e.err));
    clr();
  endtask

  initial begin
    clr();
    Reset = 1;
    #2;
    check("rst.pc",   32'(ProgCtr),  0);
    check("rst.run",  32'(Running),  0);
    check("rst.done", 32'(Done),     0);
    check("rst.err",  32'(StackErr), 0);
    #1 Reset = 0;

    // Run to 0x105, then reset asynchronously in the middle of the cycle.
    Start = 1; ProgSel = 1; step("t1.start", 10'h100, 1, 0, 0);
    for (int i = 1; i <= 5; i++) step("t1.inc", 10'h100 + 10'(i), 1, 0, 0);
    #3 Reset = 1;
    #1;
    check("t1.async.pc",  32'(ProgCtr), 0);
    check("t1.async.run", 32'(Running), 0);
    #1 Reset = 0;
    step("t1.idle", 10'h000, 0, 0, 0);

    // Launch, increment, stall, and ignore Start while running.
    Start = 1; ProgSel = 1; step("t2.start", 10'h100, 1, 0, 0);
    for (int i = 1; i <= 3; i++) step("t2.inc", 10'h100 + 10'(i), 1, 0, 0);
    Stall = 1; Jump = 1; Target = 10'h2AA; step("t2.stall1", 10'h103, 1, 0, 0);
    Stall = 1; Halt = 1; step("t2.stall2", 10'h103, 1, 0, 0);
    Start = 1; ProgSel = 2; step("t2.start_in_run", 10'h104, 1, 0, 0);

    // Wrap-around and relative branches.
    Jump = 1; Target = 10'h3FF; step("t3.jump_top", 10'h3FF, 1, 0, 0);
    step("t3.wrap", 10'h000, 1, 0, 0);
    Jump = 1; Target = 10'h005; step("t3.jump5", 10'h005, 1, 0, 0);
    Branch = 1; Taken = 1; Target = 10'h3FE; step("t3.br_neg", 10'h003, 1, 0, 0);
    Branch = 1; Taken = 0; Target = 10'h100; step("t3.br_not", 10'h004, 1, 0, 0);
    Jump = 1; Branch = 1; Taken = 1; Target = 10'h080; step("t3.jmp_pri", 10'h080, 1, 0, 0);
    Branch = 1; Taken = 1; Target = 10'h3F0; step("t3.br_back", 10'h070, 1, 0, 0);
    Jump = 1; Target = 10'h3FD; step("t3.jump_hi", 10'h3FD, 1, 0, 0);
    Branch = 1; Taken = 1; Target = 10'h005; step("t3.br_wrap", 10'h002, 1, 0, 0);

    // Halt, ignore controls in DONE, relaunch.
    Jump = 1; Target = 10'h020; step("t4.jump", 10'h020, 1, 0, 0);
    Halt = 1; Jump = 1; Target = 10'h0AA; step("t4.halt", 10'h020, 0, 1, 0);
    Jump = 1; Target = 10'h001; step("t4.jump_done", 10'h020, 0, 1, 0);
    Start = 1; ProgSel = 3; step("t4.badsel", 10'h020, 0, 1, 0);
    Start = 1; ProgSel = 2; step("t4.start2", 10'h200, 1, 0, 0);
    Start = 1; ProgSel = 0; step("t4.ignored", 10'h201, 1, 0, 0);

`ifdef CALL_STACK_EN
    Jump = 1; Target = 10'h010; step("t5.jump", 10'h010, 1, 0, 0);
    Call = 1; Target = 10'h050; step("t5.call", 10'h050, 1, 0, 0);
    Ret = 1; Call = 1; Target = 10'h3AA; step("t5.ret", 10'h011, 1, 0, 0);
    Call = 1; Target = 10'h060; step("t5.c1", 10'h060, 1, 0, 0);
    Call = 1; Target = 10'h070; step("t5.c2", 10'h070, 1, 0, 0);
    Stall = 1; Call = 1; Target = 10'h3C0; step("t5.stall", 10'h070, 1, 0, 0);
    Call = 1; Target = 10'h080; step("t5.c3", 10'h080, 1, 0, 0);
    Call = 1; Target = 10'h090; step("t5.c4", 10'h090, 1, 0, 0);
    Call = 1; Target = 10'h0A0; step("t5.c5_full", 10'h0A0, 1, 0, 1);
    Ret = 1; step("t5.r4", 10'h081, 1, 0, 1);
    Ret = 1; step("t5.r3", 10'h071, 1, 0, 1);
    Ret = 1; step("t5.r2", 10'h061, 1, 0, 1);
    Ret = 1; step("t5.r1", 10'h012, 1, 0, 1);
    Ret = 1; step("t5.r_empty", 10'h013, 1, 0, 1);
    Halt = 1; step("t5.halt", 10'h013, 0, 1, 1);
    Start = 1; ProgSel = 0; step("t5.restart", 10'h000, 1, 0, 0);
    Ret = 1; step("t5.r_empty2", 10'h001, 1, 0, 1);
`else
    Jump = 1; Target = 10'h010; step("t6.jump", 10'h010, 1, 0, 0);
    Call = 1; Target = 10'h050; step("t6.call", 10'h011, 1, 0, 0);
    Ret = 1; step("t6.ret", 10'h012, 1, 0, 0);
    Call = 1; Jump = 1; Target = 10'h050; step("t6.call_jump", 10'h050, 1, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
